iic_slave_regfile: RTL and testbench

Parametrised I2C slave register-file model for the axis_iic_bridge benches, and synthesizable for loopback on hardware. It decodes START, repeated START and STOP, answers only its own 7-bit address, and ACKs address and write bytes. It supports 1- or 2-byte register pointers with auto-increment and wrap, sequential reads ended by a master NACK, and optional SCL clock stretching. A write-strobe side port exposes every register update to the bench scoreboard.

---
 rtl/iic_slave_pkg.sv | 25 ++
 rtl/iic_line_sync.sv | 33 +++
 rtl/iic_slave_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_iic_slave_regfile.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_slave_pkg.sv
// Shared FSM encoding, bus-level constants and pointer-width helper for the I2C slave register file.
package iic_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_PTR_ADDR,
    S_PTR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } iic_state_e;

  localparam logic IIC_ACK     = 1'b0;
  localparam logic IIC_NACK    = 1'b1;
  localparam logic IIC_RW_READ = 1'b1;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iic_line_sync.sv
// Two-flop synchronizer for one open-drain line, plus registered rise/fall strobes.
// Strobes and the aligned level appear 3 CLK after the pin changes.
module iic_line_sync (
  input  logic CLK,
  input  logic RESETN,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // Reset to the idle-high bus level so that release from reset never fakes an edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q <= 3'b111;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], line_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level_o = sync_q[2];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/iic_slave_regfile.sv
// I2C slave register file: 7-bit address, 1/2-byte auto-incrementing pointer, sequential reads, optional SCL stretch.
// Bits sampled 4 CLK after the SCL pin rises; SDA_O changes 4 CLK after the SCL pin falls.
module iic_slave_regfile
  import iic_slave_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR    = 7'h50,
  parameter int         PTR_BYTES      = 1,
  parameter int         REG_DEPTH      = 256,
  parameter int         STRETCH_CYCLES = 0,
  parameter int         INIT_PATTERN   = 1
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         IIC_SCL_I,
  input  logic                         IIC_SDA_I,
  output logic                         IIC_SCL_O,
  output logic                         IIC_SDA_O,
  output logic                         WR_STROBE,
  output logic [$clog2(REG_DEPTH)-1:0] WR_ADDR,
  output logic [7:0]                   WR_DATA,
  output logic                         BUSY
);

  localparam int          PW           = ptr_width(REG_DEPTH);
  localparam logic [15:0] STRETCH_LOAD = 16'(STRETCH_CYCLES);

  iic_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      shift_q, shift_d;
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [1:0]      pbyte_q, pbyte_d;
  logic            rw_q, rw_d;
  logic            mack_q, mack_d;
  logic            sda_o_q, sda_o_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic [PW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [15:0]     stretch_q, stretch_d;
  logic [7:0]      regs_q [REG_DEPTH];
  logic [7:0]      byte_in, rd_byte, rd_next;
  logic            scl_lvl, scl_rise, scl_fall;
  logic            sda_lvl, sda_rise, sda_fall;
  logic            start_det, stop_det;

  iic_line_sync u_scl_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .line_i (IIC_SCL_I),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  iic_line_sync u_sda_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .line_i (IIC_SDA_I),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift_q, sda_lvl};
  assign ptr_inc   = ptr_q + 1'b1;
  assign rd_byte   = regs_q[ptr_q];
  assign rd_next   = regs_q[ptr_inc];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    pbyte_d   = pbyte_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    sda_o_d   = sda_o_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    stretch_d = (stretch_q != 16'd0) ? stretch_q - 16'd1 : 16'd0;

    if (start_det) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = 3'd0;
      sda_o_d   = 1'b1;
    end else if (stop_det) begin
      state_d = S_IDLE;
      sda_o_d = 1'b1;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_DEV_ADDR, S_PTR_ADDR, S_WR_DATA: begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              S_DEV_ADDR: begin
                if (byte_in[7:1] == DEVICE_ADDR) begin
                  state_d = S_DEV_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                end
              end
              // Shifting whole bytes into the pointer leaves (MSB:LSB) mod REG_DEPTH after the last one.
              S_PTR_ADDR: begin
                ptr_d   = PW'({ptr_q, byte_in});
                pbyte_d = pbyte_q + 2'd1;
                state_d = S_PTR_ACK;
              end
              default: begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_inc;
                state_d   = S_WR_ACK;
              end
            endcase
          end
        end
        S_RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_RD_ACK;
        end
        S_RD_ACK: mack_d = sda_lvl;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        // First fall opens the 9th bit, second fall closes it and starts any stretch.
        S_DEV_ACK, S_PTR_ACK, S_WR_ACK, S_RD_ACK: begin
          if (bit_cnt_q == 3'd0) begin
            sda_o_d   = (state_q == S_RD_ACK) ? 1'b1 : IIC_ACK;
            bit_cnt_d = 3'd1;
          end else begin
            bit_cnt_d = 3'd0;
            sda_o_d   = 1'b1;
            stretch_d = STRETCH_LOAD;
            case (state_q)
              S_DEV_ACK: begin
                if (rw_q == IIC_RW_READ) begin
                  state_d = S_RD_DATA;
                  sda_o_d = rd_byte[7];
                end else begin
                  state_d = S_PTR_ADDR;
                  pbyte_d = 2'd0;
                end
              end
              S_PTR_ACK: state_d = (pbyte_q == 2'(PTR_BYTES)) ? S_WR_DATA : S_PTR_ADDR;
              S_WR_ACK:  state_d = S_WR_DATA;
              default: begin
                if (mack_q == IIC_ACK) begin
                  ptr_d   = ptr_inc;
                  state_d = S_RD_DATA;
                  sda_o_d = rd_next[7];
                end else begin
                  state_d = S_IGNORE;
                end
              end
            endcase
          end
        end
        S_RD_DATA: if (bit_cnt_q != 3'd0) sda_o_d = rd_byte[3'd7 - bit_cnt_q];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      ptr_q     <= '0;
      pbyte_q   <= 2'd0;
      rw_q      <= 1'b0;
      mack_q    <= IIC_NACK;
      sda_o_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      stretch_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      pbyte_q   <= pbyte_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      sda_o_q   <= sda_o_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stretch_q <= stretch_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
    end else if (wr_stb_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign IIC_SCL_O = (stretch_q == 16'd0);
  assign IIC_SDA_O = sda_o_q;
  assign WR_STROBE = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_iic_slave_regfile.sv
// Directed bench: bit-banged I2C master on a shared bus with a plain slave (0x50) and a stretching slave (0x60).
module tb_iic_slave_regfile;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       dut_scl, dut_sda, dut_stb, dut_busy;
  logic [7:0] dut_waddr, dut_wdata;
  logic       str_scl, str_sda, str_stb, str_busy;
  logic [7:0] str_waddr, str_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  assign scl_bus = m_scl & dut_scl & str_scl;
  assign sda_bus = m_sda & dut_sda & str_sda;

  always #5 clk = ~clk;

  iic_slave_regfile #(.DEVICE_ADDR(7'h50)) u_dut (
    .CLK(clk), .RESETN(rst_n), .IIC_SCL_I(scl_bus), .IIC_SDA_I(sda_bus),
    .IIC_SCL_O(dut_scl), .IIC_SDA_O(dut_sda), .WR_STROBE(dut_stb),
    .WR_ADDR(dut_waddr), .WR_DATA(dut_wdata), .BUSY(dut_busy)
  );

  iic_slave_regfile #(.DEVICE_ADDR(7'h60), .STRETCH_CYCLES(10)) u_str (
    .CLK(clk), .RESETN(rst_n), .IIC_SCL_I(scl_bus), .IIC_SDA_I(sda_bus),
    .IIC_SCL_O(str_scl), .IIC_SDA_O(str_sda), .WR_STROBE(str_stb),
    .WR_ADDR(str_waddr), .WR_DATA(str_wdata), .BUSY(str_busy)
  );

  // Monitors sample on the falling clock edge, away from DUT updates.
  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int busy_cnt = 0;
  int str_low  = 0;
  int str_run  = 0;
  int str_max  = 0;
  int str_stb_cnt = 0;

  always @(negedge clk) begin
    if (dut_stb === 1'b1) begin
      log_addr.push_back(dut_waddr);
      log_data.push_back(dut_wdata);
    end
    if (dut_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (str_stb === 1'b1) str_stb_cnt <= str_stb_cnt + 1;
    if (str_scl === 1'b0) begin
      str_low <= str_low + 1;
      str_run <= str_run + 1;
      if (str_run + 1 > str_max) str_max <= str_run + 1;
    end else begin
      str_run <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scl_high();
    int k;
    k = 0;
    #1;
    while (scl_bus !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    if (scl_bus !== 1'b1) begin
      n_fail++;
      $error("FAIL scl_release_timeout observed=%b expected=1", scl_bus);
    end
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    tick(10); m_sda = b;
    tick(10); m_scl = 1'b1;
    wait_scl_high();
    tick(10); s = sda_bus;
    tick(10); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(10); m_sda = 1'b1;
    tick(10); m_scl = 1'b1;
    wait_scl_high();
    tick(20); m_sda = 1'b0;
    tick(20); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(10); m_sda = 1'b0;
    tick(10); m_scl = 1'b1;
    wait_scl_high();
    tick(20); m_sda = 1'b1;
    tick(20);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(nack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         n0, b0, s0;

    // Reset state
    tick(5);
    check("rst_scl_o", dut_scl, 1'b1);
    check("rst_sda_o", dut_sda, 1'b1);
    check("rst_strobe", dut_stb, 1'b0);
    check("rst_wr_addr", dut_waddr, 8'h00);
    check("rst_wr_data", dut_wdata, 8'h00);
    check("rst_busy", dut_busy, 1'b0);
    rst_n = 1'b1;
    tick(10);

    // Single write 0x10 <= 0xA5, then read it back
    i2c_start();
    send_byte(8'hA0, ack); check("w1_addr_ack", ack, 1'b0);
    check("w1_busy", dut_busy, 1'b1);
    send_byte(8'h10, ack); check("w1_ptr_ack", ack, 1'b0);
    send_byte(8'hA5, ack); check("w1_data_ack", ack, 1'b0);
    i2c_stop();
    check("w1_busy_after_stop", dut_busy, 1'b0);
    check("w1_strobe_count", log_addr.size(), 1);
    check("w1_wr_addr", log_addr[0], 8'h10);
    check("w1_wr_data", log_data[0], 8'hA5);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h10, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("r1_addr_ack", ack, 1'b0);
    recv_byte(1'b1, d);    check("r1_data", d, 8'hA5);
    i2c_stop();

    // Pointer wrap: 0xFE, 0xFF, 0x00
    n0 = log_addr.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFE, ack);
    send_byte(8'h11, ack); check("wrap_ack0", ack, 1'b0);
    send_byte(8'h22, ack); check("wrap_ack1", ack, 1'b0);
    send_byte(8'h33, ack); check("wrap_ack2", ack, 1'b0);
    i2c_stop();
    check("wrap_count", log_addr.size() - n0, 3);
    check("wrap_addr0", log_addr[n0],     8'hFE);
    check("wrap_addr1", log_addr[n0 + 1], 8'hFF);
    check("wrap_addr2", log_addr[n0 + 2], 8'h00);
    check("wrap_data0", log_data[n0],     8'h11);
    check("wrap_data1", log_data[n0 + 1], 8'h22);
    check("wrap_data2", log_data[n0 + 2], 8'h33);

    // Sequential read from 0x20 through repeated START, last byte NACKed
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("seq_addr_ack", ack, 1'b0);
    recv_byte(1'b0, d);    check("seq_byte0", d, 8'h20);
    recv_byte(1'b0, d);    check("seq_byte1", d, 8'h21);
    recv_byte(1'b1, d);    check("seq_byte2", d, 8'h22);
    tick(8);
    check("seq_sda_released", dut_sda, 1'b1);
    i2c_stop();

    // Foreign address 0x51: NACK, no write, BUSY stays low
    n0 = log_addr.size();
    b0 = busy_cnt;
    i2c_start();
    send_byte(8'hA2, ack); check("foreign_addr_nack", ack, 1'b1);
    send_byte(8'h33, ack); check("foreign_data_nack", ack, 1'b1);
    i2c_stop();
    check("foreign_no_strobe", log_addr.size() - n0, 0);
    check("foreign_busy_low", busy_cnt - b0, 0);

    // Stretching slave: 3 ACK bits, 10 CLK each
    s0 = str_low;
    i2c_start();
    send_byte(8'hC0, ack); check("str_addr_ack", ack, 1'b0);
    send_byte(8'h03, ack); check("str_ptr_ack", ack, 1'b0);
    send_byte(8'h5A, ack); check("str_data_ack", ack, 1'b0);
    i2c_stop();
    check("str_low_total", str_low - s0, 30);
    check("str_low_run", str_max, 10);
    check("str_strobes", str_stb_cnt, 1);
    check("str_wr_addr", str_waddr, 8'h03);
    check("str_wr_data", str_wdata, 8'h5A);
    check("str_busy_after_stop", str_busy, 1'b0);

    // Reset halfway through a read data byte
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    send_byte(8'h70, ack);
    i2c_stop();
    check("rstx_prewrite_data", log_data[log_data.size() - 1], 8'h70);
    n0 = log_addr.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, s);
    tick(8);
    check("rstx_sda_driven", dut_sda, 1'b0);
    rst_n = 1'b0;
    tick(1);
    check("rstx_sda_o", dut_sda, 1'b1);
    check("rstx_scl_o", dut_scl, 1'b1);
    check("rstx_busy", dut_busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    i2c_stop();
    check("rstx_no_strobe", log_addr.size() - n0, 0);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("rstx_read_ack", ack, 1'b0);
    recv_byte(1'b1, d);    check("rstx_reg05", d, 8'h05);
    i2c_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
